// File: rtl/sub_pkg.sv
// sub_pkg: shared state encoding and sizing helpers for serial_subtractor.
package sub_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic int steps_of(input int width, input int digit);
    return width / digit;
  endfunction
  function automatic int cnt_w(input int steps);
    return (steps <= 1) ? 1 : $clog2(steps);
  endfunction
endpackage

// File: rtl/fs_slice.sv
// fs_slice: DIGIT-wide ripple-borrow chain of full-subtractor cells.
module fs_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo
);
  logic [DIGIT:0] c;
  assign c[0] = bi;
  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    assign d[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (~(a[i] ^ b[i]) & c[i]) | (~a[i] & b[i]);
  end
  assign bo = c[DIGIT];
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: computes a - b - bin over WIDTH bits, DIGIT bits per clock,
// with valid/ready handshakes on both sides.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);
  localparam int STEPS = steps_of(WIDTH, DIGIT);
  localparam int CW = cnt_w(STEPS);
  if (WIDTH % DIGIT != 0) begin : g_bad
    $error("serial_subtractor: WIDTH must be a multiple of DIGIT");
  end
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, diff_q, diff_d, r_nxt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic br_q, br_d, am_q, am_d, bm_q, bm_d, rdy_q, rdy_d;
  logic bout_q, bout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [DIGIT-1:0] d;
  logic bo;
  fs_slice #(.DIGIT(DIGIT)) u_slice (
    .a (a_q[DIGIT-1:0]),
    .b (b_q[DIGIT-1:0]),
    .bi(br_q),
    .d (d),
    .bo(bo)
  );
  // Result bits enter from the MSB side so the LSB digit lands at bit 0 last.
  if (STEPS == 1) begin : g_one
    assign r_nxt = d;
  end else begin : g_shift
    assign r_nxt = {d, r_q[WIDTH-1:DIGIT]};
  end
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    br_d    = br_q;
    am_d    = am_q;
    bm_d    = bm_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    if (state_q == IDLE && in_valid && rdy_q) begin
      a_d     = a;
      b_d     = b;
      br_d    = bin;
      am_d    = a[WIDTH-1];
      bm_d    = b[WIDTH-1];
      cnt_d   = '0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      a_d   = a_q >> DIGIT;
      b_d   = b_q >> DIGIT;
      r_d   = r_nxt;
      br_d  = bo;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(STEPS - 1)) begin
        state_d = DONE;
        diff_d  = r_nxt;
        bout_d  = bo;
        ovf_d   = (am_q != bm_q) & (r_nxt[WIDTH-1] != am_q);
        zero_d  = ~|r_nxt;
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
    rdy_d = (state_d == IDLE);
  end
  // in_ready is a registered copy of "next state is IDLE" so it stays low in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      br_q    <= 1'b0;
      am_q    <= 1'b0;
      bm_q    <= 1'b0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      br_q    <= br_d;
      am_q    <= am_d;
      bm_q    <= bm_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end
  assign in_ready  = rdy_q;
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed checks of the 8-bit/2-digit subtractor plus
// exhaustive 4-bit sweeps at DIGIT = 1, 2 and 4.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [7:0] a = '0, b = '0, diff;
  logic bin = 1'b0, bout, ovf, zero;
  logic v4 = 1'b0, or4 = 1'b1, bin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [2:0] rdy4, ov4, bo4, ovf4, z4;
  logic [3:0] d4 [3];
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  serial_subtractor #(.WIDTH(8), .DIGIT(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
  );
  for (genvar k = 0; k < 3; k++) begin : g4
    serial_subtractor #(.WIDTH(4), .DIGIT(1 << k)) u4 (
      .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4[k]),
      .a(a4), .b(b4), .bin(bin4), .out_valid(ov4[k]), .out_ready(or4),
      .diff(d4[k]), .bout(bo4[k]), .ovf(ovf4[k]), .zero(z4[k])
    );
  end
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin, output int lat);
    int w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
    end
    a = ta; b = tb; bin = tbin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
  endtask
  task automatic test_reset();
    #2;
    tests++;
    if ({in_ready, out_valid, diff, bout, ovf, zero} !== 13'd0) begin
      fails++;
      $display("FAIL reset_outputs: rdy=%b ov=%b diff=%h flags=%b%b%b required all 0",
               in_ready, out_valid, diff, bout, ovf, zero);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
    end
  endtask
  task automatic test_basic();
    int lat;
    out_ready = 1'b1;
    do_op(8'h05, 8'h03, 1'b0, lat);
    tests++;
    if (lat !== 4 || {diff, bout, ovf, zero} !== {8'h02, 3'b000}) begin
      fails++;
      $display("FAIL basic: lat=%0d diff=%h b/o/z=%b%b%b required lat=4 diff=02 b/o/z=000",
               lat, diff, bout, ovf, zero);
    end
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_pulse: out_valid=%b required 0", out_valid);
    end
  endtask
  task automatic test_wrap();
    int lat;
    do_op(8'h00, 8'h01, 1'b0, lat);
    tests++;
    if (lat !== 4 || {diff, bout, ovf, zero} !== {8'hFF, 3'b100}) begin
      fails++;
      $display("FAIL wrap_0m1: lat=%0d diff=%h b/o/z=%b%b%b required lat=4 diff=ff b/o/z=100",
               lat, diff, bout, ovf, zero);
    end
    do_op(8'h80, 8'h01, 1'b0, lat);
    tests++;
    if (lat !== 4 || {diff, bout, ovf, zero} !== {8'h7F, 3'b010}) begin
      fails++;
      $display("FAIL ovf_80m1: lat=%0d diff=%h b/o/z=%b%b%b required lat=4 diff=7f b/o/z=010",
               lat, diff, bout, ovf, zero);
    end
  endtask
  task automatic test_borrow_in();
    int lat;
    do_op(8'h10, 8'h0F, 1'b1, lat);
    tests++;
    if (lat !== 4 || {diff, bout, ovf, zero} !== {8'h00, 3'b001}) begin
      fails++;
      $display("FAIL bin_zero: lat=%0d diff=%h b/o/z=%b%b%b required lat=4 diff=00 b/o/z=001",
               lat, diff, bout, ovf, zero);
    end
    do_op(8'h00, 8'h00, 1'b1, lat);
    tests++;
    if (lat !== 4 || {diff, bout, ovf, zero} !== {8'hFF, 3'b100}) begin
      fails++;
      $display("FAIL bin_wrap: lat=%0d diff=%h b/o/z=%b%b%b required lat=4 diff=ff b/o/z=100",
               lat, diff, bout, ovf, zero);
    end
  endtask
  task automatic test_backpressure();
    int lat;
    @(posedge clk); #1;
    out_ready = 1'b0;
    do_op(8'h5A, 8'h21, 1'b0, lat);
    tests++;
    if (lat !== 4 || diff !== 8'h39) begin
      fails++;
      $display("FAIL bp_first: lat=%0d diff=%h required lat=4 diff=39", lat, diff);
    end
    a = 8'h44; b = 8'h11; bin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests++;
      if ({out_valid, in_ready, diff, bout, ovf, zero} !== {2'b10, 8'h39, 3'b000}) begin
        fails++;
        $display("FAIL bp_hold%0d: ov=%b rdy=%b diff=%h b/o/z=%b%b%b required ov=1 rdy=0 diff=39 b/o/z=000",
                 i, out_valid, in_ready, diff, bout, ovf, zero);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      fails++;
      $display("FAIL bp_release: ov=%b rdy=%b required ov=0 rdy=1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_accept: in_ready=%b required 0", in_ready);
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    tests++;
    if (lat !== 4 || diff !== 8'h33) begin
      fails++;
      $display("FAIL bp_second: lat=%0d diff=%h required lat=4 diff=33", lat, diff);
    end
    @(posedge clk); #1;
  endtask
  task automatic test_reset_mid_run();
    int lat;
    int pulses = 0;
    a = 8'h77; b = 8'h01; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({in_ready, out_valid, diff, bout, ovf, zero} !== 13'd0) begin
      fails++;
      $display("FAIL async_reset: rdy=%b ov=%b diff=%h b/o/z=%b%b%b required all 0",
               in_ready, out_valid, diff, bout, ovf, zero);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    tests++;
    if (pulses !== 0) begin
      fails++;
      $display("FAIL abort_no_valid: pulses=%0d required 0", pulses);
    end
    do_op(8'h33, 8'h11, 1'b0, lat);
    tests++;
    if (lat !== 4 || diff !== 8'h22) begin
      fails++;
      $display("FAIL post_reset: lat=%0d diff=%h required lat=4 diff=22", lat, diff);
    end
    @(posedge clk); #1;
  endtask
  task automatic test_exhaustive();
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++) begin
          logic [4:0] exp;
          logic [2:0] seen;
          int sa, sb, r;
          logic eovf;
          exp = 5'(x) - 5'(y) - 5'(c);
          sa = (x >= 8) ? x - 16 : x;
          sb = (y >= 8) ? y - 16 : y;
          r = sa - sb - c;
          eovf = (r < -8) || (r > 7);
          if (rdy4 !== 3'b111) begin
            tests++; fails++;
            $display("FAIL ex_ready: rdy=%b required 111", rdy4);
          end
          a4 = 4'(x); b4 = 4'(y); bin4 = 1'(c); v4 = 1'b1;
          @(posedge clk); #1;
          v4 = 1'b0;
          seen = '0;
          for (int cyc = 1; cyc <= 6; cyc++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++)
              if (ov4[k] && !seen[k]) begin
                seen[k] = 1'b1;
                tests++;
                if (cyc != (4 >> k) || {bo4[k], d4[k]} !== exp || ovf4[k] !== eovf ||
                    z4[k] !== (exp[3:0] == 4'd0)) begin
                  fails++;
                  $display("FAIL ex_d%0d %0d-%0d-%0d: lat=%0d res=%h ovf=%b z=%b required lat=%0d res=%h ovf=%b z=%b",
                           1 << k, x, y, c, cyc, {bo4[k], d4[k]}, ovf4[k], z4[k],
                           4 >> k, exp, eovf, exp[3:0] == 4'd0);
                end
              end
          end
          if (seen !== 3'b111) begin
            tests++; fails++;
            $display("FAIL ex_timeout %0d-%0d-%0d: seen=%b required 111", x, y, c, seen);
          end
        end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_borrow_in();
    test_backpressure();
    test_reset_mid_run();
    test_exhaustive();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
